// File: rtl/instruction_encoder_if.sv
// Request/response bundle for the RV32 instruction encoder.
// slave is the encoder's view, master the loader/memory side.
interface instruction_encoder_if #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [XLEN-1:0]      in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_inst;
  logic                 out_error;
  logic [ERR_CNT_W-1:0] error_count;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2,
    input  in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_error,
    output error_count
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2,
    output in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_error,
    input  error_count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Two-stage RV32 instruction encoder: classify and range-check,
// then scatter fields into the instruction word.
module instruction_encoder #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 16
) (
  input logic                  clock,
  input logic                  reset,
  instruction_encoder_if.slave bus
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S,
    FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            err;
  } s1_t;

  s1_t        s1_d, s1_q;
  logic       s1_valid;
  logic       s1_adv, s2_adv;
  logic [31:0] word;
  logic [XLEN-1:0] imm;
  logic       fits12, fits13, fits21, shamt_ok, is_shift;

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign imm      = bus.in_imm;
  assign fits12   = (&imm[31:11]) || !(|imm[31:11]);
  assign fits13   = (&imm[31:12]) || !(|imm[31:12]);
  assign fits21   = (&imm[31:20]) || !(|imm[31:20]);
  assign shamt_ok = !(|imm[31:5]);
  assign is_shift = (bus.in_opcode == OPC_OP_IMM) &&
                    (bus.in_funct3[1:0] == 2'b01);

  always_comb begin
    s1_d        = '0;
    s1_d.opcode = bus.in_opcode;
    s1_d.rd     = bus.in_rd;
    s1_d.rs1    = bus.in_rs1;
    s1_d.rs2    = bus.in_rs2;
    s1_d.funct3 = bus.in_funct3;
    s1_d.funct7 = bus.in_funct7;
    s1_d.imm    = bus.in_imm;
    s1_d.fmt    = FMT_X;
    case (bus.in_opcode)
      OPC_LOAD, OPC_LOAD_FP,
      OPC_OP_IMM, OPC_JALR:   s1_d.fmt = is_shift ? FMT_SH : FMT_I;
      OPC_STORE, OPC_STORE_FP: s1_d.fmt = FMT_S;
      OPC_BRANCH:             s1_d.fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:     s1_d.fmt = FMT_U;
      OPC_JAL:                s1_d.fmt = FMT_J;
      OPC_OP:                 s1_d.fmt = FMT_R;
      default:                s1_d.fmt = FMT_X;
    endcase
    case (s1_d.fmt)
      FMT_I, FMT_S: s1_d.err = !fits12;
      FMT_SH:       s1_d.err = !shamt_ok;
      FMT_B:        s1_d.err = !fits13 || imm[0];
      FMT_J:        s1_d.err = !fits21 || imm[0];
      FMT_U:        s1_d.err = |imm[11:0];
      FMT_R:        s1_d.err = 1'b0;
      default:      s1_d.err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  always_comb begin
    word = '0;
    if (!s1_q.err) begin
      unique case (1'b1)
        s1_q.fmt == FMT_I:
          word = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3,
                  s1_q.rd, s1_q.opcode};
        s1_q.fmt == FMT_SH:
          word = {s1_q.funct7, s1_q.imm[4:0], s1_q.rs1,
                  s1_q.funct3, s1_q.rd, s1_q.opcode};
        s1_q.fmt == FMT_S:
          word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1,
                  s1_q.funct3, s1_q.imm[4:0], s1_q.opcode};
        s1_q.fmt == FMT_B:
          word = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2,
                  s1_q.rs1, s1_q.funct3, s1_q.imm[4:1],
                  s1_q.imm[11], s1_q.opcode};
        s1_q.fmt == FMT_U:
          word = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
        s1_q.fmt == FMT_J:
          word = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                  s1_q.imm[19:12], s1_q.rd, s1_q.opcode};
        s1_q.fmt == FMT_R:
          word = {s1_q.funct7, s1_q.rs2, s1_q.rs1,
                  s1_q.funct3, s1_q.rd, s1_q.opcode};
        default: word = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= '0;
      bus.out_error <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_inst  <= word;
        bus.out_error <= s1_q.err;
      end
    end
  end

  // Counts retired errored words; sticks at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.error_count <= '0;
    end else if (bus.out_valid && bus.out_ready &&
                 bus.out_error && !(&bus.error_count)) begin
      bus.error_count <= bus.error_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: vectors, backpressure,
// reset flush and error counter saturation.
module tb_instruction_encoder;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  instruction_encoder_if #(.XLEN(32), .ERR_CNT_W(16)) bus ();

  instruction_encoder #(.XLEN(32), .ERR_CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_in  = 0;
  int   n_out = 0;
  exp_t q[$];
  exp_t nx;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [6:0] op, logic [4:0] rd,
                       logic [4:0] rs1, logic [4:0] rs2,
                       logic [2:0] f3, logic [6:0] f7,
                       logic [31:0] imm, logic [31:0] ei,
                       logic ee);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    nx.inst       = ei;
    nx.err        = ee;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    exp_t e;
    #2;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("extra_word", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("inst", bus.out_inst, e.inst);
        chk("err", {31'd0, bus.out_error}, {31'd0, e.err});
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      n_in++;
      q.push_back(nx);
    end
    @(negedge clock);
  endtask

  task automatic drain(int budget);
    bus.in_valid = 1'b0;
    for (int i = 0; i < budget && q.size() != 0; i++) cycle();
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    int c;
    int base;
    logic [31:0] held;

    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    nx.inst = '0;
    nx.err  = 1'b0;

    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_inst", bus.out_inst, 32'd0);
    chk("rst_err", {31'd0, bus.out_error}, 32'd0);
    chk("rst_cnt", {16'd0, bus.error_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clock);

    // addi x1,x2,-1 with latency check
    drive(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
          32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    cycle();
    chk("lat1", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1 chk("lat2", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clock);
    drain(10);

    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
          32'h1234_5000, 32'h1234_52B7, 1'b0);
    cycle();
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
          32'h1234_5001, 32'h0, 1'b1);
    cycle();
    drain(10);
    chk("cnt_lui", {16'd0, bus.error_count}, 32'd1);

    drive(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
          32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
    cycle();
    drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
          32'd8, 32'h0020_8463, 1'b0);
    cycle();
    drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
          32'd7, 32'h0, 1'b1);
    cycle();
    drive(7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0,
          32'd31, 32'h01F1_1093, 1'b0);
    cycle();
    drive(7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20,
          32'd5, 32'h4052_5193, 1'b0);
    cycle();
    drive(7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0,
          32'd32, 32'h0, 1'b1);
    cycle();
    drive(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0,
          32'hFFFF_FFFC, 32'hFE51_2E23, 1'b0);
    cycle();
    drive(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
          32'd2047, 32'h7FF1_0093, 1'b0);
    cycle();
    drive(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
          32'd2048, 32'h0, 1'b1);
    cycle();
    drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
          32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    cycle();
    drive(7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
          32'd0, 32'h0, 1'b1);
    cycle();
    drain(20);
    chk("cnt_dir", {16'd0, bus.error_count}, 32'd5);

    // 8-word stream with a 5-cycle downstream stall
    base = n_out;
    n_in = 0;
    c = 0;
    while (n_out - base < 8 && c < 40) begin
      bus.out_ready = !(c >= 3 && c < 8);
      if (n_in < 8) begin
        drive(7'h13, 5'(n_in + 1), 5'd0, 5'd0, 3'd0, 7'd0,
              32'(n_in + 1),
              (32'(n_in + 1) << 20) | (32'(n_in + 1) << 7)
              | 32'h13, 1'b0);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c == 3) held = bus.out_inst;
      if (c >= 4 && c < 8) begin
        chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_inst", bus.out_inst, held);
      end
      cycle();
      c++;
    end
    chk("stream_out", n_out - base, 8);
    chk("stream_in", n_in, 8);
    bus.out_ready = 1'b1;

    // reset with two words in flight
    drive(7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0,
          32'd9, 32'h0090_0493, 1'b0);
    cycle();
    drive(7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,
          32'd10, 32'h00A0_0513, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_inst", bus.out_inst, 32'd0);
    chk("flush_err", {31'd0, bus.out_error}, 32'd0);
    chk("flush_cnt", {16'd0, bus.error_count}, 32'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    #1 chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clock);
    base = n_out;
    for (int i = 0; i < 6; i++) cycle();
    chk("flush_none", n_out - base, 0);

    // error counter saturation
    n_in = 0;
    c = 0;
    drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
          32'd0, 32'h0, 1'b1);
    while (n_in < 65539 && c < 70000) begin
      cycle();
      c++;
    end
    chk("sat_in", n_in, 65539);
    drain(10);
    chk("sat_cnt", {16'd0, bus.error_count}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Pipelined RV32 instruction encoder: packs opcode, register fields, function fields and a 32-bit immediate into a 32-bit instruction word.
- It is the inverse of the core's immediate decode path, scattering immediate bits into I/S/B/U/J positions.
- Range-checks each immediate against its format.
- Sits between the test-program/AES-kernel loader and instruction memory, with valid/ready on both sides and a saturating error counter.

Parameters:
- XLEN, 32, data width; only 32 supported.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept the request
- in_opcode  input  7  uses the codebase `OPCODE_* values
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field; also imm[11:5] for shift-immediates
- in_imm  input  XLEN  byte-offset or value immediate, two's complement
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts
- out_inst  output  32  encoded instruction
- out_error  output  1  qualifies out_inst; immediate out of range or opcode unsupported
- error_count  output  ERR_CNT_W  saturating count of errored words accepted downstream

Behaviour:
- Reset (reset=0, asynchronous): both stage valids=0, out_valid=0, out_inst=0, out_error=0, error_count=0. in_ready=1 after reset release.
- Reset mid-operation drops all in-flight words; nothing is emitted for them.
- Pipeline, stage S1 (capture, classify, range-check):
  - S1 latches all in_* fields.
  - Computes format: LOAD/LOAD_FP/OP_IMM/JALR = I; STORE/STORE_FP = S; BRANCH = B; LUI/AUIPC = U; JAL = J; OP = R; anything else = error.
  - Computes range error.
- Pipeline, stage S2 (assemble): builds the word and drives the out_* registers.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput: 1 word/cycle.
- Handshake rules:
  - Input accepted when in_valid & in_ready.
  - Output retired when out_valid & out_ready.
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from state and out_ready).
  - While out_valid=1 and out_ready=0: out_inst and out_error stay stable, and no data is lost.
  - Simultaneous retire and new arrival in the same cycle is a full-rate pass-through.
- Encoding (inst[6:0] = opcode throughout):
  - I: {imm[11:0], rs1, funct3, rd}.
  - I shift (OP_IMM with funct3 001 or 101): {funct7, imm[4:0], rs1, funct3, rd}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0]}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]}.
  - U: {imm[31:12], rd}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
  - R: {funct7, rs2, rs1, funct3, rd}; imm ignored.
- Range errors:
  - I and S: imm outside [-2048, 2047].
  - I shift: imm outside [0, 31].
  - B: imm outside [-4096, 4094] or imm[0]=1.
  - J: imm outside [-1048576, 1048574] or imm[0]=1.
  - U: imm[11:0] != 0.
  - Unsupported opcode.
- On any error: out_inst=32'h0, out_error=1.
- error_count increments on each retired word with out_error=1 and saturates at all-ones without wrapping.

Test Plan:
- Reset, then encode addi x1,x2,-1 (opcode 0010011, rd=1, rs1=2, f3=0, imm=-1) -> out_valid two cycles later; out_inst=32'hFFF10093, out_error=0.
- lui x5 imm=32'h12345000 -> 32'h123452B7. Same opcode with imm=32'h12345001 -> out_inst=0, out_error=1, error_count=1.
- jal x0,-4 -> 32'hFFDFF06F. beq x1,x2,8 -> 32'h00208463. beq with imm=7 -> out_error=1.
- Stream 8 back-to-back words while holding out_ready=0 for 5 cycles mid-stream:
  - in_ready drops after 2 words are held.
  - out_inst stays stable while stalled.
  - All 8 words emerge in order with no duplicates.
- Assert reset with 2 words in flight -> outputs clear immediately; no words are emitted after release.
- Drive 2^16+3 errored words -> error_count holds at 16'hFFFF.
